// File: rtl/pitch_shift_pkg.sv
// Shared types and constants for the pitch-shift STFT front end.
// Holds the frame-scheduler state encoding and the hop-length derivation.
package pitch_shift_pkg;

  localparam int unsigned DEFAULT_ADDRWIDTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } frame_state_t;

  // Hop is half the window: 50% overlap between consecutive frames.
  function automatic int unsigned hop_len(input int unsigned addrwidth);
    return (32'd1 << addrwidth) >> 1;
  endfunction

endpackage

// File: rtl/stft_frame_scheduler_if.sv
// Sample-in / window-out handshake bundle for the STFT frame scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface stft_frame_scheduler_if
  import pitch_shift_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = DEFAULT_ADDRWIDTH
);

  logic                 sample_valid;
  logic                 sample_ready;
  logic                 out_ready;
  logic                 enqueue;
  logic                 dequeue;
  logic                 out_valid;
  logic                 out_first;
  logic                 out_last;
  logic [ADDRWIDTH-1:0] window_index;

  modport master (
    output sample_valid,
    output out_ready,
    input  sample_ready,
    input  enqueue,
    input  dequeue,
    input  out_valid,
    input  out_first,
    input  out_last,
    input  window_index
  );

  modport slave (
    input  sample_valid,
    input  out_ready,
    output sample_ready,
    output enqueue,
    output dequeue,
    output out_valid,
    output out_first,
    output out_last,
    output window_index
  );

endinterface

// File: rtl/stft_frame_scheduler.sv
// Schedules 50%-overlap STFT frames over a window FIFO: counts buffered samples,
// streams N-sample windows on consumer credit and retires H samples per frame.
module stft_frame_scheduler
  import pitch_shift_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = DEFAULT_ADDRWIDTH
)(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  stft_frame_scheduler_if.slave  bus,
  output logic                   overrun
);

  localparam int unsigned           N        = 32'd1 << ADDRWIDTH;
  localparam int unsigned           H        = hop_len(ADDRWIDTH);
  localparam logic [ADDRWIDTH:0]    OCC_FULL = (ADDRWIDTH+1)'(N);
  localparam logic [ADDRWIDTH:0]    OCC_HOP  = (ADDRWIDTH+1)'(H);
  localparam logic [ADDRWIDTH:0]    OCC_ONE  = (ADDRWIDTH+1)'(1);
  localparam logic [ADDRWIDTH-1:0]  IDX_ONE  = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0]  IDX_LAST = '1;

  frame_state_t           r_state;
  frame_state_t           w_next_state;
  logic [ADDRWIDTH:0]     r_occ;
  logic [ADDRWIDTH-1:0]   r_rd_idx;
  logic                   r_out_valid;
  logic                   r_out_first;
  logic                   r_out_last;
  logic [ADDRWIDTH-1:0]   r_window_index;
  logic                   r_overrun;

  logic                   w_sample_ready;
  logic                   w_enqueue;
  logic                   w_dequeue;
  logic                   w_frame_done;

  assign w_sample_ready = (r_occ < OCC_FULL);
  assign w_enqueue      = bus.sample_valid && w_sample_ready;
  assign w_frame_done   = w_dequeue && (r_rd_idx == IDX_LAST);

  // enable is only sampled at the last beat in STREAM, so frames never truncate.
  always_comb begin
    w_next_state = r_state;
    w_dequeue    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next_state = FILL;
      end
      FILL: begin
        if (!enable)                 w_next_state = IDLE;
        else if (r_occ == OCC_FULL)  w_next_state = STREAM;
      end
      STREAM: begin
        w_dequeue = bus.out_ready;
        if (bus.out_ready && (r_rd_idx == IDX_LAST))
          w_next_state = enable ? FILL : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // occ never enqueues while full, so the hop subtraction and an increment cannot coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_occ          <= '0;
      r_rd_idx       <= '0;
      r_out_valid    <= 1'b0;
      r_out_first    <= 1'b0;
      r_out_last     <= 1'b0;
      r_window_index <= '0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_frame_done)   r_occ <= r_occ - OCC_HOP;
      else if (w_enqueue) r_occ <= r_occ + OCC_ONE;

      if (w_dequeue) begin
        r_rd_idx       <= r_rd_idx + IDX_ONE;
        r_window_index <= r_rd_idx;
      end

      r_out_valid <= w_dequeue;
      r_out_first <= w_dequeue && (r_rd_idx == '0);
      r_out_last  <= w_frame_done;

      if (bus.sample_valid && !w_sample_ready) r_overrun <= 1'b1;
    end
  end

  assign bus.sample_ready = w_sample_ready;
  assign bus.enqueue      = w_enqueue;
  assign bus.dequeue      = w_dequeue;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_first    = r_out_first;
  assign bus.out_last     = r_out_last;
  assign bus.window_index = r_window_index;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_stft_frame_scheduler.sv
// Directed bench for stft_frame_scheduler with N=8, H=4.
module tb_stft_frame_scheduler;
  import pitch_shift_pkg::*;

  localparam int unsigned AW = 3;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic overrun;
  int   n_pass  = 0;
  int   n_total = 0;

  stft_frame_scheduler_if #(.ADDRWIDTH(AW)) bus ();

  stft_frame_scheduler #(.ADDRWIDTH(AW)) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .bus     (bus),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns number of cycles until out_valid is seen; limit on timeout.
  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    @(negedge clock);
    while (bus.out_valid !== 1'b1 && cnt < limit) begin
      step();
      @(negedge clock);
      cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; bus.sample_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    step();
    @(negedge clock);
    n_total++; if (dut.r_state !== IDLE) $display("FAIL rst_state: got %0d want %0d", dut.r_state, IDLE); else n_pass++;
    n_total++; if (dut.r_occ !== 4'd0) $display("FAIL rst_occ: got %0d want 0", dut.r_occ); else n_pass++;
    n_total++; if (dut.r_rd_idx !== 3'd0) $display("FAIL rst_rd_idx: got %0d want 0", dut.r_rd_idx); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_first !== 1'b0) $display("FAIL rst_out_first: got %b want 0", bus.out_first); else n_pass++;
    n_total++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", bus.out_last); else n_pass++;
    n_total++; if (bus.window_index !== 3'd0) $display("FAIL rst_index: got %0d want 0", bus.window_index); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", overrun); else n_pass++;
    n_total++; if (bus.dequeue !== 1'b0) $display("FAIL rst_dequeue: got %b want 0", bus.dequeue); else n_pass++;
    step();
    reset = 1'b0; enable = 1'b0; bus.sample_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clock);
    n_total++; if (bus.sample_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", bus.sample_ready); else n_pass++;
  endtask

  task automatic test_first_frame();
    logic [AW-1:0] e;
    step();
    enable = 1'b1; bus.sample_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_total++; if (bus.enqueue !== 1'b1) $display("FAIL f1_enqueue[%0d]: got %b want 1", i, bus.enqueue); else n_pass++;
      step();
    end
    bus.sample_valid = 1'b0;
    @(negedge clock);
    n_total++; if (dut.r_state !== FILL) $display("FAIL f1_fill_state: got %0d want %0d", dut.r_state, FILL); else n_pass++;
    n_total++; if (dut.r_occ !== 4'd8) $display("FAIL f1_occ_full: got %0d want 8", dut.r_occ); else n_pass++;
    n_total++; if (bus.dequeue !== 1'b0) $display("FAIL f1_no_deq_fill: got %b want 0", bus.dequeue); else n_pass++;
    n_total++; if (bus.sample_ready !== 1'b0) $display("FAIL f1_ready_full: got %b want 0", bus.sample_ready); else n_pass++;
    step();
    @(negedge clock);
    n_total++; if (dut.r_state !== STREAM) $display("FAIL f1_stream_state: got %0d want %0d", dut.r_state, STREAM); else n_pass++;
    n_total++; if (bus.dequeue !== 1'b1) $display("FAIL f1_deq_first: got %b want 1", bus.dequeue); else n_pass++;
    for (int b = 0; b < 8; b++) begin
      e = b[AW-1:0];
      step();
      @(negedge clock);
      n_total++; if (bus.out_valid !== 1'b1) $display("FAIL f1_valid[%0d]: got %b want 1", b, bus.out_valid); else n_pass++;
      n_total++; if (bus.window_index !== e) $display("FAIL f1_index[%0d]: got %0d want %0d", b, bus.window_index, e); else n_pass++;
      n_total++; if (bus.out_first !== (b == 0)) $display("FAIL f1_first[%0d]: got %b want %b", b, bus.out_first, (b == 0)); else n_pass++;
      n_total++; if (bus.out_last !== (b == 7)) $display("FAIL f1_last[%0d]: got %b want %b", b, bus.out_last, (b == 7)); else n_pass++;
    end
    step();
    @(negedge clock);
    n_total++; if (dut.r_state !== FILL) $display("FAIL f1_after_state: got %0d want %0d", dut.r_state, FILL); else n_pass++;
    n_total++; if (dut.r_occ !== 4'd4) $display("FAIL f1_after_occ: got %0d want 4", dut.r_occ); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL f1_after_valid: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_second_frame();
    int cnt;
    logic [AW-1:0] e;
    step();
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_total++; if (bus.sample_ready !== 1'b1) $display("FAIL f2_ready[%0d]: got %b want 1", i, bus.sample_ready); else n_pass++;
      step();
    end
    bus.sample_valid = 1'b0;
    wait_valid(20, cnt);
    n_total++; if (cnt !== 2) $display("FAIL f2_latency: got %0d want 2", cnt); else n_pass++;
    for (int b = 0; b < 8; b++) begin
      e = b[AW-1:0];
      if (b > 0) begin step(); @(negedge clock); end
      n_total++; if (bus.window_index !== e || bus.out_valid !== 1'b1) $display("FAIL f2_beat[%0d]: got %b/%0d want 1/%0d", b, bus.out_valid, bus.window_index, e); else n_pass++;
      if (b < 7) begin
        n_total++; if (dut.r_occ !== 4'd8) $display("FAIL f2_occ[%0d]: got %0d want 8", b, dut.r_occ); else n_pass++;
        n_total++; if (bus.sample_ready !== 1'b0) $display("FAIL f2_ready_stream[%0d]: got %b want 0", b, bus.sample_ready); else n_pass++;
      end
    end
    n_total++; if (dut.r_occ !== 4'd4) $display("FAIL f2_after_occ: got %0d want 4", dut.r_occ); else n_pass++;
    n_total++; if (bus.sample_ready !== 1'b1) $display("FAIL f2_after_ready: got %b want 1", bus.sample_ready); else n_pass++;
  endtask

  task automatic test_credit_toggle();
    logic want_deq, want_val;
    logic [AW-1:0] e;
    step();
    bus.sample_valid = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.sample_valid = 1'b0;
    step();
    for (int j = 0; j <= 16; j++) begin
      bus.out_ready = (j % 2 == 0);
      want_deq = (j % 2 == 0) && (j <= 14);
      want_val = (j % 2 == 1) && (j <= 15);
      e = 3'((j - 1) / 2);
      @(negedge clock);
      n_total++; if (bus.dequeue !== want_deq) $display("FAIL ct_dequeue[%0d]: got %b want %b", j, bus.dequeue, want_deq); else n_pass++;
      n_total++; if (bus.out_valid !== want_val) $display("FAIL ct_valid[%0d]: got %b want %b", j, bus.out_valid, want_val); else n_pass++;
      if (want_val) begin
        n_total++; if (bus.window_index !== e) $display("FAIL ct_index[%0d]: got %0d want %0d", j, bus.window_index, e); else n_pass++;
        n_total++; if (bus.out_first !== (j == 1) || bus.out_last !== (j == 15)) $display("FAIL ct_marks[%0d]: got %b%b want %b%b", j, bus.out_first, bus.out_last, (j == 1), (j == 15)); else n_pass++;
      end
      step();
    end
    @(negedge clock);
    n_total++; if (dut.r_state !== FILL) $display("FAIL ct_after_state: got %0d want %0d", dut.r_state, FILL); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int cnt;
    logic [AW-1:0] e;
    step();
    bus.out_ready = 1'b1; bus.sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.sample_valid = 1'b0;
    wait_valid(20, cnt);
    n_total++; if (cnt !== 2) $display("FAIL ed_latency: got %0d want 2", cnt); else n_pass++;
    for (int b = 0; b < 8; b++) begin
      e = b[AW-1:0];
      if (b > 0) begin
        step();
        if (b == 3) enable = 1'b0;
        @(negedge clock);
      end
      n_total++; if (bus.window_index !== e || bus.out_valid !== 1'b1) $display("FAIL ed_beat[%0d]: got %b/%0d want 1/%0d", b, bus.out_valid, bus.window_index, e); else n_pass++;
    end
    n_total++; if (dut.r_state !== IDLE) $display("FAIL ed_idle: got %0d want %0d", dut.r_state, IDLE); else n_pass++;
    step();
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.sample_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      n_total++; if (bus.dequeue !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL ed_no_frame[%0d]: got %b%b want 00", k, bus.dequeue, bus.out_valid); else n_pass++;
      n_total++; if (dut.r_state !== IDLE) $display("FAIL ed_stay_idle[%0d]: got %0d want %0d", k, dut.r_state, IDLE); else n_pass++;
      step();
    end
    @(negedge clock);
    n_total++; if (dut.r_occ !== 4'd8) $display("FAIL ed_occ: got %0d want 8", dut.r_occ); else n_pass++;
  endtask

  task automatic test_overrun();
    step();
    @(negedge clock);
    n_total++; if (overrun !== 1'b0) $display("FAIL ov_before: got %b want 0", overrun); else n_pass++;
    step();
    bus.sample_valid = 1'b1;
    @(negedge clock);
    n_total++; if (bus.sample_ready !== 1'b0 || bus.enqueue !== 1'b0) $display("FAIL ov_reject: got %b%b want 00", bus.sample_ready, bus.enqueue); else n_pass++;
    step();
    bus.sample_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_total++; if (overrun !== 1'b1) $display("FAIL ov_sticky[%0d]: got %b want 1", k, overrun); else n_pass++;
      step();
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midframe();
    int cnt;
    logic [AW-1:0] e;
    step();
    enable = 1'b1; bus.out_ready = 1'b1;
    wait_valid(20, cnt);
    n_total++; if (cnt !== 3) $display("FAIL rm_latency: got %0d want 3", cnt); else n_pass++;
    for (int b = 0; b <= 5; b++) begin
      e = b[AW-1:0];
      if (b > 0) begin
        step();
        if (b == 5) reset = 1'b1;
        @(negedge clock);
      end
      n_total++; if (bus.window_index !== e || bus.out_valid !== 1'b1) $display("FAIL rm_beat[%0d]: got %b/%0d want 1/%0d", b, bus.out_valid, bus.window_index, e); else n_pass++;
    end
    n_total++; if (overrun !== 1'b1) $display("FAIL rm_overrun_held: got %b want 1", overrun); else n_pass++;
    step();
    @(negedge clock);
    n_total++; if (dut.r_state !== IDLE) $display("FAIL rm_state: got %0d want %0d", dut.r_state, IDLE); else n_pass++;
    n_total++; if (dut.r_occ !== 4'd0) $display("FAIL rm_occ: got %0d want 0", dut.r_occ); else n_pass++;
    n_total++; if (dut.r_rd_idx !== 3'd0) $display("FAIL rm_rd_idx: got %0d want 0", dut.r_rd_idx); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rm_overrun: got %b want 0", overrun); else n_pass++;
    n_total++; if (bus.window_index !== 3'd0 || bus.out_first !== 1'b0 || bus.out_last !== 1'b0) $display("FAIL rm_outputs: got %0d/%b%b want 0/00", bus.window_index, bus.out_first, bus.out_last); else n_pass++;
    reset = 1'b0; enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_credit_toggle();
    test_enable_drop();
    test_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
